m_dm_ctrl: RTL and testbench

M_DM_CTRL -- requirements
Module: m_dm_ctrl

---
 rtl/m_dm_ctrl_if.sv | 41 ++++
 rtl/m_dm_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_m_dm_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_dm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : m_dm_ctrl_if
//  Description : Bundle of M-stage request/response signals between the
//                pipeline, the data-memory controller and the memory port.
//                slave  : the controller (receives Addr/WD/types, mem_ack,
//                         mem_rdata; drives Stall, RD, exceptions, mem_*)
//                master : the pipeline/memory side (opposite directions)
//  Revision    : 1.0  initial release
// ============================================================================
interface m_dm_ctrl_if;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [2:0]  DMReadEN;
    logic [2:0]  DMWriteEN;
    logic        Stall;
    logic [31:0] RD;
    logic        Exc_AdEL;
    logic        Exc_AdES;
    logic        Exc_BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  Addr, WD, DMReadEN, DMWriteEN, mem_ack, mem_rdata,
        output Stall, RD, Exc_AdEL, Exc_AdES, Exc_BusErr,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output Addr, WD, DMReadEN, DMWriteEN, mem_ack, mem_rdata,
        input  Stall, RD, Exc_AdEL, Exc_AdES, Exc_BusErr,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/m_dm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : m_dm_ctrl
//  Description : M-stage data-memory controller. Turns a load/store request
//                into a single registered memory transaction, stalls the
//                pipeline while it is outstanding, and returns the
//                sign-extended load result in RD during a one-cycle DONE
//                state. Misaligned accesses raise Exc_AdEL/Exc_AdES without
//                touching memory.
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - m_dm_ctrl_if.slave (pipeline + memory signals)
//  Parameters  : TIMEOUT  - BUSY cycles without mem_ack before bus error
//  Options     : M_DM_CTRL_TIMEOUT_EN - enables the BUSY timeout counter and
//                Exc_BusErr; when undefined BUSY waits forever and
//                Exc_BusErr is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module m_dm_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    m_dm_ctrl_if.slave    bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_is_load;
    logic [31:0] r_rd;

    logic        w_is_write;
    logic        w_is_read;
    logic [2:0]  w_code;
    logic [1:0]  w_size;
    logic        w_misalign;
    logic        w_idle;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load_val;

    // Request decode. A store takes priority; the load code is then ignored.
    always_comb begin
        w_is_write = |bus.DMWriteEN;
        w_is_read  = !w_is_write && (|bus.DMReadEN);
        w_code     = w_is_write ? bus.DMWriteEN : bus.DMReadEN;
        case (w_code)
            3'b010:  w_size = SZ_HALF;
            3'b011:  w_size = SZ_BYTE;
            default: w_size = SZ_WORD;
        endcase
        w_misalign = ((w_size == SZ_WORD) && (|bus.Addr[1:0])) ||
                     ((w_size == SZ_HALF) && bus.Addr[0]);
        w_idle     = (r_state == S_IDLE);
        w_start    = w_idle && (w_is_write || w_is_read) && !w_misalign;

        // Loads always fetch the whole word; lanes are picked on return.
        w_be    = 4'b1111;
        w_wdata = bus.WD;
        if (w_is_write) begin
            case (w_size)
                SZ_HALF: begin
                    w_be    = bus.Addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{bus.WD[15:0]}};
                end
                SZ_BYTE: begin
                    w_be    = 4'b0001 << bus.Addr[1:0];
                    w_wdata = {4{bus.WD[7:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = bus.WD;
                end
            endcase
        end
    end

    // Lane selection and sign extension of the returned word.
    always_comb begin
        w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_lane)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        case (r_size)
            SZ_HALF: w_load_val = {{16{w_half[15]}}, w_half};
            SZ_BYTE: w_load_val = {{24{w_byte[7]}}, w_byte};
            default: w_load_val = bus.mem_rdata;
        endcase
    end

    // Combinational outputs: decoded from the current inputs while IDLE, so
    // they also track the inputs while reset holds the state in IDLE.
    assign bus.Stall    = w_start || (r_state == S_BUSY);
    assign bus.Exc_AdEL = w_idle && w_is_read  && w_misalign;
    assign bus.Exc_AdES = w_idle && w_is_write && w_misalign;
    assign bus.RD       = r_rd;

`ifdef M_DM_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_buserr;
    assign bus.Exc_BusErr = r_buserr;
`else
    assign bus.Exc_BusErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            r_rd          <= 32'd0;
            r_size        <= SZ_WORD;
            r_lane        <= 2'd0;
            r_is_load     <= 1'b0;
`ifdef M_DM_CTRL_TIMEOUT_EN
            r_cnt         <= '0;
            r_buserr      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state       <= S_BUSY;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= w_is_write;
                        bus.mem_be    <= w_be;
                        bus.mem_addr  <= {bus.Addr[31:2], 2'b00};
                        bus.mem_wdata <= w_wdata;
                        r_size        <= w_size;
                        r_lane        <= bus.Addr[1:0];
                        r_is_load     <= w_is_read;
`ifdef M_DM_CTRL_TIMEOUT_EN
                        r_cnt         <= '0;
                        r_buserr      <= 1'b0;
`endif
                    end
                end
                S_BUSY: begin
                    // An ack in the same cycle as the timeout wins.
                    if (bus.mem_ack) begin
                        r_state     <= S_DONE;
                        bus.mem_req <= 1'b0;
                        if (r_is_load) begin
                            r_rd <= w_load_val;
                        end
`ifdef M_DM_CTRL_TIMEOUT_EN
                        r_buserr    <= 1'b0;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state     <= S_DONE;
                        bus.mem_req <= 1'b0;
                        r_buserr    <= 1'b1;
                        r_rd        <= 32'd0;
                    end else begin
                        r_cnt       <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_dm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_dm_ctrl
//  Description : Directed bench for m_dm_ctrl: reset values, lb/sh/sb
//                transactions, misaligned accesses, back-to-back lh,
//                BUSY timeout (or indefinite wait), reset during BUSY.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_m_dm_ctrl;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_err;

    m_dm_ctrl_if bus ();

    m_dm_ctrl #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_err          = 0;
        reset_n        = 1'b0;
        bus.Addr       = 32'h3;
        bus.WD         = 32'h0;
        bus.DMReadEN   = 3'b001;
        bus.DMWriteEN  = 3'b000;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;

        // Reset values; combinational outputs follow IDLE decoding.
        #3;
        chk("rst_req",    {31'd0, bus.mem_req},    32'd0);
        chk("rst_we",     {31'd0, bus.mem_we},     32'd0);
        chk("rst_be",     {28'd0, bus.mem_be},     32'd0);
        chk("rst_addr",   bus.mem_addr,            32'd0);
        chk("rst_wdata",  bus.mem_wdata,           32'd0);
        chk("rst_rd",     bus.RD,                  32'd0);
        chk("rst_buserr", {31'd0, bus.Exc_BusErr}, 32'd0);
        chk("rst_adel",   {31'd0, bus.Exc_AdEL},   32'd1);
        chk("rst_stall0", {31'd0, bus.Stall},      32'd0);
        bus.Addr = 32'h4;
        #1;
        chk("rst_stall1", {31'd0, bus.Stall},      32'd1);
        chk("rst_req2",   {31'd0, bus.mem_req},    32'd0);
        bus.DMReadEN = 3'b000;
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // lb 0x1003, ack in the second BUSY cycle: three stalled cycles.
        bus.DMReadEN = 3'b011;
        bus.Addr     = 32'h0000_1003;
        #1;
        chk("lb_stall_c1", {31'd0, bus.Stall},   32'd1);
        chk("lb_req_idle", {31'd0, bus.mem_req}, 32'd0);
        step();
        chk("lb_stall_c2", {31'd0, bus.Stall},   32'd1);
        chk("lb_req",      {31'd0, bus.mem_req}, 32'd1);
        chk("lb_addr",     bus.mem_addr,         32'h0000_1000);
        chk("lb_be",       {28'd0, bus.mem_be},  32'hF);
        chk("lb_we",       {31'd0, bus.mem_we},  32'd0);
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h80FF_7F01;
        #1;
        chk("lb_stall_c3", {31'd0, bus.Stall},   32'd1);
        chk("lb_req_hold", {31'd0, bus.mem_req}, 32'd1);
        step();
        bus.mem_ack  = 1'b0;
        bus.DMReadEN = 3'b000;
        #1;
        chk("lb_done_stall", {31'd0, bus.Stall},   32'd0);
        chk("lb_done_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("lb_rd",         bus.RD,               32'hFFFF_FF80);
        step();

        // sh 0x2002: upper half lanes, replicated data; RD untouched.
        bus.DMWriteEN = 3'b010;
        bus.Addr      = 32'h0000_2002;
        bus.WD        = 32'h0000_BEEF;
        step();
        chk("sh_req",   {31'd0, bus.mem_req}, 32'd1);
        chk("sh_we",    {31'd0, bus.mem_we},  32'd1);
        chk("sh_be",    {28'd0, bus.mem_be},  32'hC);
        chk("sh_wdata", bus.mem_wdata,        32'hBEEF_BEEF);
        chk("sh_addr",  bus.mem_addr,         32'h0000_2000);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
        bus.DMWriteEN = 3'b000;
        #1;
        chk("sh_done_stall", {31'd0, bus.Stall}, 32'd0);
        chk("sh_rd_keep",    bus.RD,             32'hFFFF_FF80);
        step();

        // sb 0x0005.
        bus.DMWriteEN = 3'b011;
        bus.Addr      = 32'h0000_0005;
        bus.WD        = 32'h1234_5678;
        step();
        chk("sb_be",    {28'd0, bus.mem_be}, 32'h2);
        chk("sb_wdata", bus.mem_wdata,       32'h7878_7878);
        chk("sb_addr",  bus.mem_addr,        32'h0000_0004);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
        bus.DMWriteEN = 3'b000;
        step();

        // Misaligned lw; a stray ack in IDLE is ignored.
        bus.DMReadEN  = 3'b001;
        bus.Addr      = 32'h0000_0001;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        #1;
        chk("lw_mis_adel",  {31'd0, bus.Exc_AdEL}, 32'd1);
        chk("lw_mis_ades",  {31'd0, bus.Exc_AdES}, 32'd0);
        chk("lw_mis_stall", {31'd0, bus.Stall},    32'd0);
        step();
        bus.mem_ack = 1'b0;
        chk("lw_mis_req",   {31'd0, bus.mem_req},  32'd0);
        chk("lw_mis_adel2", {31'd0, bus.Exc_AdEL}, 32'd1);
        chk("lw_mis_rd",    bus.RD,                32'hFFFF_FF80);

        // Misaligned sw with a load also present: the store wins.
        bus.DMWriteEN = 3'b001;
        bus.Addr      = 32'h0000_0002;
        #1;
        chk("sw_mis_ades", {31'd0, bus.Exc_AdES}, 32'd1);
        chk("sw_mis_adel", {31'd0, bus.Exc_AdEL}, 32'd0);
        step();
        chk("sw_mis_req",  {31'd0, bus.mem_req},  32'd0);
        bus.DMWriteEN = 3'b000;
        bus.DMReadEN  = 3'b000;
        step();

        // Back-to-back lh 0x10 then 0x12, separated by one DONE cycle.
        bus.DMReadEN = 3'b010;
        bus.Addr     = 32'h0000_0010;
        step();
        chk("lh1_addr", bus.mem_addr,        32'h0000_0010);
        chk("lh1_be",   {28'd0, bus.mem_be}, 32'hF);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h8001_7FFF;
        step();
        bus.mem_ack = 1'b0;
        bus.Addr    = 32'h0000_0012;
        #1;
        chk("lh1_done_stall", {31'd0, bus.Stall},   32'd0);
        chk("lh1_done_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("lh1_rd",         bus.RD,               32'h0000_7FFF);
        step();
        chk("lh2_idle_stall", {31'd0, bus.Stall},   32'd1);
        chk("lh2_idle_req",   {31'd0, bus.mem_req}, 32'd0);
        step();
        chk("lh2_addr", bus.mem_addr,         32'h0000_0010);
        chk("lh2_req",  {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack  = 1'b0;
        bus.DMReadEN = 3'b000;
        #1;
        chk("lh2_done_stall", {31'd0, bus.Stall}, 32'd0);
        chk("lh2_rd",         bus.RD,             32'hFFFF_8001);
        step();

`ifdef M_DM_CTRL_TIMEOUT_EN
        // No ack: four BUSY cycles, then DONE with a bus error and RD=0.
        bus.DMReadEN  = 3'b001;
        bus.Addr      = 32'h0000_0030;
        bus.mem_rdata = 32'h1122_3344;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("to_req_busy", {31'd0, bus.mem_req}, 32'd1);
            step();
        end
        bus.DMReadEN = 3'b000;
        #1;
        chk("to_req_drop", {31'd0, bus.mem_req},    32'd0);
        chk("to_buserr",   {31'd0, bus.Exc_BusErr}, 32'd1);
        chk("to_rd",       bus.RD,                  32'd0);
        chk("to_stall",    {31'd0, bus.Stall},      32'd0);
        step();

        // Ack on the fourth BUSY cycle beats the timeout.
        bus.DMReadEN = 3'b001;
        bus.Addr     = 32'h0000_0034;
        step();
        repeat (3) step();
        chk("to4_req", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack  = 1'b0;
        bus.DMReadEN = 3'b000;
        #1;
        chk("to4_buserr", {31'd0, bus.Exc_BusErr}, 32'd0);
        chk("to4_rd",     bus.RD,                  32'h1122_3344);
        step();
`else
        // Without the timeout, BUSY waits for as long as the ack takes.
        bus.DMReadEN  = 3'b001;
        bus.Addr      = 32'h0000_0030;
        bus.mem_rdata = 32'h1122_3344;
        step();
        repeat (20) step();
        chk("wait_req",    {31'd0, bus.mem_req},    32'd1);
        chk("wait_stall",  {31'd0, bus.Stall},      32'd1);
        chk("wait_buserr", {31'd0, bus.Exc_BusErr}, 32'd0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack  = 1'b0;
        bus.DMReadEN = 3'b000;
        #1;
        chk("wait_rd",     bus.RD,                  32'h1122_3344);
        chk("wait_buserr2", {31'd0, bus.Exc_BusErr}, 32'd0);
        step();
`endif

        // Reset in the middle of BUSY, followed by a stale ack.
        bus.DMReadEN = 3'b001;
        bus.Addr     = 32'h0000_0040;
        step();
        chk("rb_req_busy", {31'd0, bus.mem_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rb_req_now", {31'd0, bus.mem_req}, 32'd0);
        chk("rb_stall",   {31'd0, bus.Stall},   32'd1);
        chk("rb_rd",      bus.RD,               32'd0);
        bus.DMReadEN = 3'b000;
        #1;
        chk("rb_stall0",  {31'd0, bus.Stall},   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ack = 1'b0;
        #1;
        chk("rb_stale_rd",    bus.RD,               32'd0);
        chk("rb_stale_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rb_stale_stall", {31'd0, bus.Stall},   32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
